// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types and constants for the trace filter
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH            = 32;
  localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 16;
  localparam int CLASS_MASK_WIDTH                    = 5;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BRANCH    = 3'd1,
    JUMP      = 3'd2,
    WFI       = 3'd3,
    TRAP      = 3'd4,
    INTERRUPT = 3'd5
  } trace_event_class_e;

  localparam int CLASS_BIT_BRANCH    = 0;
  localparam int CLASS_BIT_JUMP      = 1;
  localparam int CLASS_BIT_WFI       = 2;
  localparam int CLASS_BIT_TRAP      = 3;
  localparam int CLASS_BIT_INTERRUPT = 4;

  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
  localparam logic [31:0] WFI_ENCODING  = 32'h10500073;

endpackage

// File: rtl/trace_instr_classifier.sv
// rtl/trace_instr_classifier.sv - decodes a retired instruction into a branch/jump/WFI one-hot
module trace_instr_classifier
  import continuous_monitoring_system_pkg::*;
#(
  parameter int INSTR_WIDTH = RISC_V_INSTRUCTION_WIDTH
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [2:0]             class_onehot
);

  localparam logic [INSTR_WIDTH-1:0] WFI_WORD = INSTR_WIDTH'(WFI_ENCODING);

  logic [6:0] opcode;
  assign opcode = instr[6:0];

  assign class_onehot[0] = (opcode == OPCODE_BRANCH);
  assign class_onehot[1] = (opcode == OPCODE_JAL) || (opcode == OPCODE_JALR);
  assign class_onehot[2] = (instr == WFI_WORD);

endmodule

// File: rtl/multi_event_trace_filter.sv
// rtl/multi_event_trace_filter.sv - programmable event-windowed trace filter
// Optional statistics counters: TRACE_FILTER_STATS_EN.
module multi_event_trace_filter
  import continuous_monitoring_system_pkg::*;
#(
  parameter int                      INSTR_WIDTH        = RISC_V_INSTRUCTION_WIDTH,
  parameter int                      COUNTER_WIDTH      = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
  parameter int                      WINDOW_WIDTH       = 4,
  parameter int                      STAT_WIDTH         = 32,
  parameter logic [4:0]              DEFAULT_CLASS_MASK = 5'b10011,
  parameter logic [WINDOW_WIDTH-1:0] DEFAULT_WINDOW_LEN = WINDOW_WIDTH'(1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_valid,
  input  logic [INSTR_WIDTH-1:0]   next_instr,
  input  logic [COUNTER_WIDTH-1:0] trap_counter,
  input  logic [COUNTER_WIDTH-1:0] interrupt_counter,
  input  logic                     cfg_load,
  input  logic [4:0]               cfg_class_mask,
  input  logic [WINDOW_WIDTH-1:0]  cfg_window_len,
  input  logic                     cfg_keep_event,
  output logic                     drop_instr,
  output logic [2:0]               send_reason,
  output logic [STAT_WIDTH-1:0]    sent_count,
  output logic [STAT_WIDTH-1:0]    dropped_count
);

  logic [4:0]               class_mask_q;
  logic [WINDOW_WIDTH-1:0]  window_len_q;
  logic                     keep_event_q;
  logic [WINDOW_WIDTH-1:0]  window_cnt_q;
  trace_event_class_e       reason_q;
  logic                     primed_q;
  logic [COUNTER_WIDTH-1:0] prev_trap_q;
  logic [COUNTER_WIDTH-1:0] prev_intr_q;

  logic [2:0]         instr_class;
  logic               branch_hit, jump_hit, wfi_hit, class_hit;
  logic               trap_hit, intr_hit, any_event;
  logic               window_open, keep;
  trace_event_class_e event_class, instr_reason, send_reason_e;

  trace_instr_classifier #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_classifier (
    .instr        (next_instr),
    .class_onehot (instr_class)
  );

  assign branch_hit = instr_class[0] & class_mask_q[CLASS_BIT_BRANCH];
  assign jump_hit   = instr_class[1] & class_mask_q[CLASS_BIT_JUMP];
  assign wfi_hit    = instr_class[2] & class_mask_q[CLASS_BIT_WFI];
  assign class_hit  = branch_hit | jump_hit | wfi_hit;

  // Counter events are suppressed until the previous-value registers are primed.
  assign trap_hit = primed_q & (trap_counter != prev_trap_q) & class_mask_q[CLASS_BIT_TRAP];
  assign intr_hit = primed_q & (interrupt_counter != prev_intr_q) & class_mask_q[CLASS_BIT_INTERRUPT];

  assign any_event   = (pc_valid & class_hit) | trap_hit | intr_hit;
  assign window_open = (window_cnt_q != '0);
  assign keep        = window_open | (keep_event_q & class_hit);
  assign drop_instr  = pc_valid & ~keep & rst_n;

  always_comb begin
    event_class = NONE;
    if (intr_hit)                   event_class = INTERRUPT;
    else if (trap_hit)              event_class = TRAP;
    else if (pc_valid && jump_hit)  event_class = JUMP;
    else if (pc_valid && branch_hit) event_class = BRANCH;
    else if (pc_valid && wfi_hit)   event_class = WFI;
  end

  always_comb begin
    instr_reason = NONE;
    if (jump_hit)        instr_reason = JUMP;
    else if (branch_hit) instr_reason = BRANCH;
    else if (wfi_hit)    instr_reason = WFI;
  end

  // An instruction kept only by keep_event reports its own class.
  always_comb begin
    send_reason_e = NONE;
    if (rst_n && pc_valid && keep) begin
      send_reason_e = window_open ? reason_q : instr_reason;
    end
  end
  assign send_reason = send_reason_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_mask_q <= DEFAULT_CLASS_MASK;
      window_len_q <= DEFAULT_WINDOW_LEN;
      keep_event_q <= 1'b0;
      window_cnt_q <= '0;
      reason_q     <= NONE;
      primed_q     <= 1'b0;
      prev_trap_q  <= '0;
      prev_intr_q  <= '0;
    end else begin
      if (cfg_load) begin
        class_mask_q <= cfg_class_mask;
        window_len_q <= cfg_window_len;
        keep_event_q <= cfg_keep_event;
      end
      primed_q    <= 1'b1;
      prev_trap_q <= trap_counter;
      prev_intr_q <= interrupt_counter;
      if (any_event) begin
        window_cnt_q <= window_len_q;
        reason_q     <= event_class;
      end else if (pc_valid && window_open) begin
        window_cnt_q <= window_cnt_q - {{(WINDOW_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef TRACE_FILTER_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  logic [STAT_WIDTH-1:0] sent_q;
  logic [STAT_WIDTH-1:0] dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q    <= '0;
      dropped_q <= '0;
    end else if (pc_valid) begin
      if (keep) begin
        if (sent_q != '1) sent_q <= sent_q + STAT_ONE;
      end else begin
        if (dropped_q != '1) dropped_q <= dropped_q + STAT_ONE;
      end
    end
  end

  assign sent_count    = sent_q;
  assign dropped_count = dropped_q;
`else
  assign sent_count    = '0;
  assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_multi_event_trace_filter.sv
// tb/tb_multi_event_trace_filter.sv - randomized bench with behavioural reference model
module tb_multi_event_trace_filter;
  import continuous_monitoring_system_pkg::*;

  localparam int IW = 32;
  localparam int CW = 16;
  localparam int WW = 4;
  localparam int SW = 4;
  localparam int STAT_MAX = (1 << SW) - 1;

  localparam logic [31:0] I_BRANCH = 32'h00029663;
  localparam logic [31:0] I_ADD    = 32'h00130013;
  localparam logic [31:0] I_JALR   = 32'h00000067;
  localparam logic [31:0] I_WFI    = 32'h10500073;
  localparam logic [31:0] I_OTHER  = 32'hDDDDDDDD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_valid = 1'b0;
  logic [IW-1:0] next_instr = '0;
  logic [CW-1:0] trap_counter = '0;
  logic [CW-1:0] interrupt_counter = '0;
  logic          cfg_load = 1'b0;
  logic [4:0]    cfg_class_mask = '0;
  logic [WW-1:0] cfg_window_len = '0;
  logic          cfg_keep_event = 1'b0;
  logic          drop_instr;
  logic [2:0]    send_reason;
  logic [SW-1:0] sent_count;
  logic [SW-1:0] dropped_count;

  always #5 clk = ~clk;

  multi_event_trace_filter #(
    .INSTR_WIDTH   (IW),
    .COUNTER_WIDTH (CW),
    .WINDOW_WIDTH  (WW),
    .STAT_WIDTH    (SW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_valid          (pc_valid),
    .next_instr        (next_instr),
    .trap_counter      (trap_counter),
    .interrupt_counter (interrupt_counter),
    .cfg_load          (cfg_load),
    .cfg_class_mask    (cfg_class_mask),
    .cfg_window_len    (cfg_window_len),
    .cfg_keep_event    (cfg_keep_event),
    .drop_instr        (drop_instr),
    .send_reason       (send_reason),
    .sent_count        (sent_count),
    .dropped_count     (dropped_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: window as a plain count of instructions still to keep.
  int          m_win, m_reason, m_len, m_sent, m_dropped;
  logic [4:0]  m_mask;
  bit          m_keep_ev, m_primed;
  logic [CW-1:0] m_prev_trap, m_prev_intr;

  function automatic void model_reset();
    m_win = 0; m_reason = 0; m_len = 1; m_mask = 5'b10011; m_keep_ev = 0;
    m_primed = 0; m_prev_trap = '0; m_prev_intr = '0; m_sent = 0; m_dropped = 0;
  endfunction

  // Returns 1 branch, 2 jump, 3 WFI, 0 otherwise.
  function automatic int class_of(input logic [31:0] ins);
    if (ins == I_WFI) return 3;
    case (ins[6:0])
      7'b1100011:             return 1;
      7'b1101111, 7'b1100111: return 2;
      default:                return 0;
    endcase
  endfunction

  function automatic int rank_of(input int c);
    case (c)
      5: return 5; 4: return 4; 2: return 3; 1: return 2; 3: return 1;
      default: return 0;
    endcase
  endfunction

  // Inputs are set by the caller just after a rising edge; outputs are checked mid-cycle.
  task automatic step(input int exp_drop, input int exp_reason);
    int  c, e_reason, best;
    bit  en, kp, e_drop, tev, iev;
    #4;
    if (!rst_n) model_reset();
    c  = class_of(next_instr);
    en = (c != 0) && m_mask[c - 1];
    kp = (m_win > 0) || (m_keep_ev && en);
    e_drop   = rst_n && pc_valid && !kp;
    e_reason = (rst_n && pc_valid && kp) ? ((m_win > 0) ? m_reason : c) : 0;
    check_eq("drop", drop_instr, e_drop);
    check_eq("reason", send_reason, e_reason);
`ifdef TRACE_FILTER_STATS_EN
    check_eq("sent_count", sent_count, m_sent);
    check_eq("dropped_count", dropped_count, m_dropped);
`else
    check_eq("sent_count", sent_count, 0);
    check_eq("dropped_count", dropped_count, 0);
`endif
    if (exp_drop >= 0) check_eq("plan_drop", drop_instr, exp_drop);
    if (exp_reason >= 0) check_eq("plan_reason", send_reason, exp_reason);
    if (rst_n) begin
      tev  = m_primed && (trap_counter != m_prev_trap) && m_mask[3];
      iev  = m_primed && (interrupt_counter != m_prev_intr) && m_mask[4];
      best = 0;
      if (iev) best = 5;
      else if (tev) best = 4;
      else if (pc_valid && en) best = c;
      if (rank_of(best) > 0) begin
        m_win = m_len; m_reason = best;
      end else if (pc_valid && m_win > 0) begin
        m_win--;
      end
      if (pc_valid) begin
        if (kp) m_sent = (m_sent < STAT_MAX) ? m_sent + 1 : STAT_MAX;
        else    m_dropped = (m_dropped < STAT_MAX) ? m_dropped + 1 : STAT_MAX;
      end
      if (cfg_load) begin
        m_mask = cfg_class_mask; m_len = cfg_window_len; m_keep_ev = cfg_keep_event;
      end
      m_primed = 1; m_prev_trap = trap_counter; m_prev_intr = interrupt_counter;
    end
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic instr(input logic [31:0] ins, input int exp_drop, input int exp_reason);
    pc_valid = 1'b1; next_instr = ins;
    step(exp_drop, exp_reason);
  endtask

  task automatic idle();
    pc_valid = 1'b0; next_instr = I_ADD;
    step(-1, -1);
  endtask

  task automatic load_cfg(input logic [4:0] mask, input logic [WW-1:0] len, input logic kev);
    cfg_load = 1'b1; cfg_class_mask = mask; cfg_window_len = len; cfg_keep_event = kev;
    idle();
  endtask

  initial begin
    logic [31:0] r;
    model_reset();
    @(posedge clk);
    #1;
    pc_valid = 1'b1; next_instr = I_ADD; trap_counter = 16'd5; interrupt_counter = 16'd7;
    step(0, 0);
    rst_n = 1'b1;
    idle();

    instr(I_BRANCH, 1, 0);
    instr(I_ADD, 0, BRANCH);
    instr(I_ADD, 1, 0);

    load_cfg(5'b10011, 4'd3, 1'b0);
    instr(I_JALR, 1, 0);
    instr(I_ADD, 0, JUMP);
    instr(I_ADD, 0, JUMP);
    instr(I_ADD, 0, JUMP);
    instr(I_ADD, 1, 0);
    instr(I_JALR, 1, 0);
    instr(I_ADD, 0, JUMP);
    instr(I_JALR, 0, JUMP);
    instr(I_ADD, 0, JUMP);
    instr(I_ADD, 0, JUMP);
    instr(I_ADD, 0, JUMP);
    instr(I_ADD, 1, 0);

    for (int i = 0; i < 3; i++) begin
      interrupt_counter = interrupt_counter + 16'd1;
      idle();
    end
    instr(I_OTHER, 0, INTERRUPT);
    instr(I_ADD, 0, INTERRUPT);
    instr(I_ADD, 0, INTERRUPT);
    instr(I_ADD, 1, 0);
    trap_counter = trap_counter + 16'd1;
    idle();
    instr(I_ADD, 1, 0);

    load_cfg(5'b00100, 4'd0, 1'b1);
    instr(I_WFI, 0, WFI);
    instr(I_ADD, 1, 0);

    load_cfg(5'b10011, 4'd3, 1'b0);
    instr(I_BRANCH, 1, 0);
    instr(I_ADD, 0, BRANCH);
    rst_n = 1'b0;
    instr(I_ADD, 0, 0);
    rst_n = 1'b1; interrupt_counter = 16'h1234; trap_counter = 16'h0abc;
    instr(I_ADD, 1, 0);
    instr(I_ADD, 1, 0);

    for (int n = 0; n < 1500; n++) begin
      pc_valid = ($urandom_range(0, 9) < 7);
      r = $urandom();
      case ($urandom_range(0, 6))
        0: r[6:0] = 7'b1100011;
        1: r[6:0] = 7'b1101111;
        2: r[6:0] = 7'b1100111;
        3: r = I_WFI;
        4: r = I_ADD;
        default: ;
      endcase
      next_instr = r;
      if ($urandom_range(0, 9) == 0) trap_counter = trap_counter + 16'd1;
      if ($urandom_range(0, 9) == 0) interrupt_counter = interrupt_counter + 16'd1;
      if ($urandom_range(0, 99) == 0) interrupt_counter = 16'hFFFF;
      if ($urandom_range(0, 99) == 0) trap_counter = 16'hFFFF;
      if ($urandom_range(0, 39) == 0) begin
        cfg_load = 1'b1;
        cfg_class_mask = 5'($urandom());
        cfg_window_len = 4'($urandom());
        cfg_keep_event = 1'($urandom());
      end
      rst_n = ($urandom_range(0, 299) != 0);
      step(-1, -1);
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_event_trace_filter.md
# multi_event_trace_filter

Programmable successor to the fixed-policy instruction trace filter. It sits between the CPU retirement trace tap and the trace storage/export path, and decides per retired instruction whether it is forwarded or dropped. The decision is based on a runtime-programmable set of event classes (branch, jump, WFI, trap, interrupt) and a runtime-programmable post-event keep window. Optional saturating statistics counters record how many instructions were sent and how many were dropped.

## Interface
- INSTR_WIDTH, RISC_V_INSTRUCTION_WIDTH: instruction width.
- COUNTER_WIDTH, PERFORMANCE_EVENT_MOD_COUNTER_WIDTH: width of the trap/interrupt HPM counter inputs.
- WINDOW_WIDTH, 4: width of the keep-window length and down-counter.
- STAT_WIDTH, 32: width of the statistics counters.
- DEFAULT_CLASS_MASK, 5'b10011: class mask value after reset (branch, jump, interrupt enabled).
- DEFAULT_WINDOW_LEN, 1: keep-window length after reset.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc_valid  in  1  next_instr is a newly retired instruction this cycle.
- next_instr  in  INSTR_WIDTH  retired instruction encoding.
- trap_counter  in  COUNTER_WIDTH  HPM trap count.
- interrupt_counter  in  COUNTER_WIDTH  HPM interrupt count.
- cfg_load  in  1  one-cycle pulse; latches the cfg_* inputs.
- cfg_class_mask  in  5  bit0 branch, bit1 jump, bit2 WFI, bit3 trap, bit4 interrupt.
- cfg_window_len  in  WINDOW_WIDTH  number of retired instructions kept after an event; 0 disables keeping.
- cfg_keep_event  in  1  also keep the event-class instruction itself.
- drop_instr  out  1  current pc_valid instruction must be dropped.
- send_reason  out  3  class that armed the window in use; NONE when not sending.
- sent_count  out  STAT_WIDTH  saturating count of kept instructions.
- dropped_count  out  STAT_WIDTH  saturating count of dropped instructions.

## Operation
- Classification (combinational):
  - BRANCH: opcode 7'b1100011.
  - JUMP: JAL 7'b1101111 or JALR 7'b1100111.
  - WFI: encoding 32'h10500073.
  - Only the classes enabled in the mask are considered.
- Counter events:
  - A TRAP or INTERRUPT event occurs when the counter differs from its registered previous value.
  - Counter events are detected regardless of pc_valid.
  - In the first cycle after reset deassertion the previous values are primed from the inputs, and no event is raised.
- Keep rule, evaluated when pc_valid=1:
  - keep = (window_cnt != 0) or (cfg_keep_event and the instruction is in an enabled class).
  - drop_instr = pc_valid & ~keep & rst_n.
  - drop_instr is 0 whenever pc_valid=0.
- Window update, priority order each cycle:
  1. An enabled event this cycle (instruction class with pc_valid=1, or a counter event) loads window_cnt ← cfg_window_len. This is a full restart, not additive, so a new event while the window is open reloads it.
  2. Otherwise, pc_valid=1 with window_cnt != 0 decrements window_cnt.
- The current instruction is always judged with the pre-update window_cnt. A counter event in cycle t affects instructions from t+1 onward.
- Reason register:
  - On a load, it latches the highest-priority simultaneous class: INTERRUPT > TRAP > JUMP > BRANCH > WFI.
  - send_reason shows the latched reason while a kept instruction is presented; otherwise NONE.
- Configuration: cfg_load latches the mask, window length and keep_event at the clock edge. It takes effect from the next cycle. An open window is not truncated.
- Statistics: each pc_valid cycle increments sent_count (kept) or dropped_count (dropped). Both counters saturate at all-ones.

## Timing
- drop_instr and send_reason are same-cycle combinational outputs. All state updates on the rising clk edge.
- Reset values:
  - window_cnt=0, reason=NONE, primed=0.
  - Mask, window length and keep_event take their DEFAULT_* / 0 values.
  - Statistics counters = 0.
  - drop_instr=0 and send_reason=NONE while rst_n=0.
- Reset asserted mid-window clears the window immediately. Instructions after release are dropped until a new event occurs.
- With cfg_window_len=0: only event instructions with keep_event=1 are sent.
- Counter wrap-around (all-ones → 0) counts as a change and therefore as an event.

## Configuration
- TRACE_FILTER_STATS_EN defined: the statistics counters are implemented.
- Not defined: no counter flops; sent_count and dropped_count are tied to 0.

## Structure
- Additions to continuous_monitoring_system_pkg:
  - trace_event_class_e: NONE, BRANCH, JUMP, WFI, TRAP, INTERRUPT.
  - Class-mask bit index localparams.
  - Opcode constants and the WFI_ENCODING constant.
- Sub-module trace_instr_classifier: combinational decode of next_instr into a 3-class one-hot (branch, jump, WFI).

## Test plan
- Reset defaults, window 1: branch 32'h00029663 then ADD 32'h00130013 then ADD → drop_instr 1, 0, 1; send_reason BRANCH on the kept ADD.
- window_len=3 via cfg_load, JALR 32'h00000067, then 4 ADDs → drops 1, 0, 0, 0, 1. A second JALR on the 2nd ADD slot reloads the window to 3.
- Increment interrupt_counter with pc_valid=0 for 3 cycles, then pc_valid=1 with 32'hDDDDDDDD → kept, send_reason INTERRUPT. A trap increment with mask bit3=0 → no effect.
- keep_event=1, window_len=0, mask WFI only: WFI 32'h10500073 → kept; following ADD → dropped.
- Reset pulse while window_cnt=2 → after release an ADD is dropped. No spurious event from nonzero counter inputs on the priming cycle.
- TRACE_FILTER_STATS_EN: 10 kept, 5 dropped → sent_count=10, dropped_count=5. With STAT_WIDTH=4 the counters saturate at 15.
